// File: rtl/hw_multiplier.sv
// hw_multiplier
//   Memory-mapped 16x16 multiplier with a 32-bit result and an optional
//   multiply-accumulate. The register window is 16 bytes at BASE. The product
//   is built by an iterative shift-add engine, one multiplier bit per cycle.
//
//   Build option: define HW_MULTIPLIER_MAC_EN to enable the MAC/MACS
//   registers (offsets 0x4/0x6) and the accumulate adder.
//
// Ports
//   clk      system clock, rising edge
//   rst      asynchronous reset, active high
//   MAB_in   address bus (MAB_in[3:1] selects the register, bit 0 ignored)
//   MDB_in   write data bus
//   MW       write strobe
//   BW       byte access (low byte only)
//   MDB_out  combinational read data, 0 when not hit
//   hit      address falls on a mapped register of this window
//   busy     a multiply is in progress
module hw_multiplier #(
    parameter logic [15:0] BASE = 16'h0130
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] MAB_in,
    input  logic [15:0] MDB_in,
    input  logic        MW,
    input  logic        BW,
    output logic [15:0] MDB_out,
    output logic        hit,
    output logic        busy
);

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_CALC = 2'd1, S_DONE = 2'd2} state_t;

    state_t      r_state, w_next;
    logic [15:0] r_op1, r_op2, r_sumext;
    logic [1:0]  r_mode, r_wmode;
    logic [31:0] r_res, r_acc, r_mcand;
    logic [15:0] r_mplier;
    logic [3:0]  r_cnt;
    logic        r_neg;

    logic [2:0]  w_off;
    logic        w_mapped, w_wr, w_op1_wr, w_op2_wr, w_reslo_wr, w_reshi_wr;
    logic [15:0] w_op1_data, w_op2_data, w_res_data, w_op1_mag, w_op2_mag;
    logic [31:0] w_prod, w_res_next;
    logic [15:0] w_sumext_next;
    logic        w_unused;

    assign w_unused = MAB_in[0];
    assign w_off    = MAB_in[3:1];

`ifdef HW_MULTIPLIER_MAC_EN
    assign w_mapped = 1'b1;
`else
    assign w_mapped = (w_off != 3'd2) && (w_off != 3'd3);
`endif

    assign hit        = (MAB_in[15:4] == BASE[15:4]) && w_mapped;
    assign w_wr       = MW && hit;
    assign w_op1_wr   = w_wr && !w_off[2];
    assign w_op2_wr   = w_wr && (w_off == 3'd4);
    // Result preload is only allowed while the engine is idle.
    assign w_reslo_wr = w_wr && (w_off == 3'd5) && (r_state == S_IDLE);
    assign w_reshi_wr = w_wr && (w_off == 3'd6) && (r_state == S_IDLE);

    // Byte writes: offset bit 0 (MPYS/MACS) selects sign extension for OP1;
    // OP2 follows the currently latched mode.
    assign w_op1_data = !BW ? MDB_in :
                        (w_off[0] ? {{8{MDB_in[7]}}, MDB_in[7:0]} : {8'h00, MDB_in[7:0]});
    assign w_op2_data = !BW ? MDB_in :
                        (r_mode[0] ? {{8{MDB_in[7]}}, MDB_in[7:0]} : {8'h00, MDB_in[7:0]});
    assign w_res_data = BW ? {8'h00, MDB_in[7:0]} : MDB_in;

    // Signed modes run the engine on magnitudes; the sign is restored in DONE.
    assign w_op1_mag = (r_mode[0] && r_op1[15]) ? (16'd0 - r_op1) : r_op1;
    assign w_op2_mag = (r_mode[0] && w_op2_data[15]) ? (16'd0 - w_op2_data) : w_op2_data;
    assign w_prod    = r_neg ? (32'd0 - r_acc) : r_acc;

    // FSM: state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    // FSM: next state. An OP2 write always (re)starts CALC.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_op2_wr) w_next = S_CALC;
            S_CALC:  if (w_op2_wr) w_next = S_CALC;
                     else if (r_cnt == 4'd15) w_next = S_DONE;
            S_DONE:  w_next = w_op2_wr ? S_CALC : S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        busy = (r_state != S_IDLE);
    end

    // Final result and SUMEXT by mode.
`ifdef HW_MULTIPLIER_MAC_EN
    logic [32:0] w_sum;
    assign w_sum = {1'b0, r_res} + {1'b0, w_prod};
`endif
    always_comb begin
        w_res_next    = w_prod;
        w_sumext_next = 16'h0000;
        case (r_wmode)
            2'd1: w_sumext_next = w_prod[31] ? 16'hFFFF : 16'h0000;
`ifdef HW_MULTIPLIER_MAC_EN
            2'd2: begin
                w_res_next    = w_sum[31:0];
                w_sumext_next = {15'd0, w_sum[32]};
            end
            2'd3: begin
                w_res_next    = w_sum[31:0];
                w_sumext_next = w_sum[31] ? 16'hFFFF : 16'h0000;
            end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_op1    <= '0;
            r_op2    <= '0;
            r_mode   <= '0;
            r_wmode  <= '0;
            r_res    <= '0;
            r_sumext <= '0;
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_cnt    <= '0;
            r_neg    <= 1'b0;
        end else begin
            if (w_op1_wr) begin
                r_op1  <= w_op1_data;
                r_mode <= w_off[1:0];
            end
            if (w_op2_wr) begin
                // Capture working copies; discards any operation in flight.
                r_op2    <= w_op2_data;
                r_wmode  <= r_mode;
                r_mcand  <= {16'd0, w_op1_mag};
                r_mplier <= w_op2_mag;
                r_neg    <= r_mode[0] && (r_op1[15] ^ w_op2_data[15]);
                r_acc    <= '0;
                r_cnt    <= '0;
            end else if (r_state == S_CALC) begin
                if (r_mplier[0]) r_acc <= r_acc + r_mcand;
                r_mcand  <= r_mcand << 1;
                r_mplier <= r_mplier >> 1;
                r_cnt    <= r_cnt + 4'd1;
            end
            if (r_state == S_DONE) begin
                r_res    <= w_res_next;
                r_sumext <= w_sumext_next;
            end
            if (w_reslo_wr) r_res[15:0]  <= w_res_data;
            if (w_reshi_wr) r_res[31:16] <= w_res_data;
        end
    end

    always_comb begin
        MDB_out = 16'h0000;
        if (hit) begin
            case (w_off)
                3'd4:    MDB_out = r_op2;
                3'd5:    MDB_out = r_res[15:0];
                3'd6:    MDB_out = r_res[31:16];
                3'd7:    MDB_out = r_sumext;
                default: MDB_out = r_op1;
            endcase
        end
    end

endmodule
